cnn_seq_ctrl: RTL and testbench
===============================

# cnn_seq_ctrl

Sequencing controller for the CNN accelerator. After one `start` pulse it walks the 3x3 convolution over the 28x28 image, then the 676-to-10 fully-connected layer. It emits memory read addresses plus accumulator clear/last strobes to the MAC datapath, one beat per accepted cycle, and pulses `done` at the end. It sits between the SoC-facing register block and the conv/FC MAC array, which have no sequencing logic of their own.

## Interface
Parameters:
- `IMG_W`, 28, image side in pixels.
- `KER_W`, 3, kernel side.
- `N_OUT`, 10, FC output count.
- Derived locally, not overridable: `FEAT_W = IMG_W-KER_W+1` (26), `N_FEAT = FEAT_W*FEAT_W` (676).

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `start` input 1: begin a run; sampled only in IDLE.
- `rdy` input 1: datapath accepts the current beat.
- `busy` output 1: run in progress.
- `done` output 1: one-cycle completion pulse.
- `conv_vld` output 1: conv beat valid.
- `img_addr` output 10: pixel index, `row*IMG_W+col`.
- `ker_idx` output 4: kernel tap 0..8, `ky*3+kx`.
- `feat_addr` output 10: feature index `r*FEAT_W+c`; conv write address, FC read address.
- `fc_vld` output 1: FC beat valid.
- `wt_addr` output 13: weight index `f*N_OUT+o`.
- `out_idx` output 4: FC output neuron `o`.
- `acc_clr` output 1: first beat of an accumulation.
- `acc_last` output 1: final beat of an accumulation.

## Operation
- States: IDLE, CONV, FC, DONE.
- IDLE, `start`=1 -> CONV, with all counters zeroed. `start` is ignored in every other state.
- CONV loop order, outermost first: r 0..25, c 0..25, ky 0..2, kx 0..2.
  - `img_addr = (r+ky)*28 + (c+kx)`.
  - `acc_clr` is high when ky=kx=0; `acc_last` is high when ky=kx=2.
- Last CONV beat accepted (r=c=25, tap 8) -> FC.
- FC loop order: o 0..9 outer, f 0..675 inner.
  - `feat_addr = f`, `wt_addr = f*10+o`, `out_idx = o`.
  - `acc_clr` is high at f=0; `acc_last` is high at f=675.
- Last FC beat accepted -> DONE. DONE -> IDLE unconditionally, with `done`=1 for that one cycle.
- Beat advance: counters step only when `(conv_vld|fc_vld) && rdy`. While `rdy`=0, every beat output holds its value.
- `conv_vld` and `fc_vld` are never high together. Both are 0 in IDLE and DONE.
- Addresses are computed incrementally (running row base plus offsets); no multipliers in the RTL. Every address stays in range: `img_addr` ≤ 783, `wt_addr` ≤ 6759.
- `busy` = state is CONV or FC.

## Timing
- All outputs are registered.
- Reset value of every output is 0; state resets to IDLE.
- `reset` asserted mid-run: immediate return to IDLE, no `done`, and the next `start` begins a full run from zero.
- With `rdy` tied 1 and `start` sampled at cycle 0:
  - Conv beats occupy cycles 1..6084.
  - FC beats occupy cycles 6085..12844.
  - `done`=1 at cycle 12845, with `busy`=0 in the same cycle.
  - Cycle 12846 is IDLE, and a new `start` may be sampled there.
- Each `rdy`=0 cycle adds exactly one cycle to the total.
- Switching from CONV to FC costs no bubble.

## Configuration
- `CNN_SEQ_PERF_EN` defined:
  - Adds output `perf_cycles` [31:0], which counts cycles while `busy`=1 and saturates at 0xFFFFFFFF.
  - It is cleared on `start` acceptance and on `reset`, and holds its value after `done`.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Shared package `cnn_pkg`:
  - Contains the state enum (IDLE/CONV/FC/DONE) and constants `IMG_W`, `KER_W`, `N_OUT`, `FEAT_W`, `N_FEAT`.
  - Also contains the address widths (10/10/13).
- One sub-module, `cnn_nested_cnt`: a parameterised wrap counter with enable, wrap flag and synchronous clear.
  - CONV instantiates four of them (r, c, ky, kx); FC reuses two (o, f).

## Test plan
- Full run with `rdy`=1, `start` at cycle 0:
  - `done` at exactly cycle 12845.
  - 6084 conv beats, 6760 FC beats.
  - 676 `acc_clr` and 676 `acc_last` strobes during conv; 10 each during FC.
- Address spot checks:
  - Conv beat 0 gives `img_addr`=0.
  - Beat 8 gives `img_addr`=58, `ker_idx`=8, `acc_last`=1.
  - Final conv beat gives `img_addr`=783, `feat_addr`=675.
  - First FC beat with o=1 gives `wt_addr`=1, `feat_addr`=0.
  - Final FC beat gives `wt_addr`=6759.
- Backpressure: random `rdy` at 50% duty. Required:
  - Outputs stable whenever `rdy`=0.
  - Accepted beat sequence identical to the `rdy`=1 run.
  - `done` delayed by exactly the number of `rdy`=0 cycles.
- `start` pulsed at cycles 100 and 7000 of a run: no effect, and `done` still at 12845.
- `reset` asserted at cycle 5000:
  - All outputs are 0 on the next sample.
  - A restart reproduces the beat-0 addresses, and `done` arrives 12845 cycles after the new `start`.
- With `CNN_SEQ_PERF_EN` defined, `rdy`=1: `perf_cycles`=12844 after `done`, unchanged 100 cycles later.

Source files
------------

// File: rtl/cnn_seq_ctrl_pkg.sv
// Shared constants, address widths and FSM state codes for the CNN sequencing controller.
package cnn_pkg;

    localparam int IMG_W  = 28;
    localparam int KER_W  = 3;
    localparam int N_OUT  = 10;
    localparam int FEAT_W = IMG_W - KER_W + 1;
    localparam int N_FEAT = FEAT_W * FEAT_W;

    localparam int IMG_AW  = 10;
    localparam int FEAT_AW = 10;
    localparam int WT_AW   = 13;

    // Sequencer states, kept as plain constants for compatibility with older tooling
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CONV = 2'd1;
    localparam state_t ST_FC   = 2'd2;
    localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/cnn_seq_ctrl_if.sv
// Control/beat bundle between the register block, the sequencer and the MAC datapath.
// CNN_SEQ_PERF_EN adds the perf_cycles counter output.
interface cnn_seq_ctrl_if;
    import cnn_pkg::*;

    logic                start;
    logic                rdy;
    logic                busy;
    logic                done;
    logic                conv_vld;
    logic [IMG_AW-1:0]   img_addr;
    logic [3:0]          ker_idx;
    logic [FEAT_AW-1:0]  feat_addr;
    logic                fc_vld;
    logic [WT_AW-1:0]    wt_addr;
    logic [3:0]          out_idx;
    logic                acc_clr;
    logic                acc_last;
`ifdef CNN_SEQ_PERF_EN
    logic [31:0]         perf_cycles;
`endif

    modport master (
        input  start, rdy,
        output busy, done, conv_vld, img_addr, ker_idx, feat_addr,
               fc_vld, wt_addr, out_idx, acc_clr, acc_last
`ifdef CNN_SEQ_PERF_EN
        , output perf_cycles
`endif
    );

    modport slave (
        output start, rdy,
        input  busy, done, conv_vld, img_addr, ker_idx, feat_addr,
               fc_vld, wt_addr, out_idx, acc_clr, acc_last
`ifdef CNN_SEQ_PERF_EN
        , input perf_cycles
`endif
    );

endinterface

// File: rtl/cnn_seq_ctrl_nested_cnt.sv
// Wrap counter used as one level of a nested loop nest: counts 0..MAX when enabled,
// flags the wrap so the next outer level can step, and exposes its next value.
module cnn_nested_cnt
    import cnn_pkg::*;
#(
    parameter int W   = 4,
    parameter int MAX = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] nxt,
    output logic         wrap
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt;

    // Next-count and wrap decode; clear has priority over counting
    always_comb begin
        wrap = en && (cnt == MAX_V);
        nxt  = cnt;
        if (clr || wrap) begin
            nxt = '0;
        end else if (en) begin
            nxt = cnt + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= nxt;
        end
    end

endmodule

// File: rtl/cnn_seq_ctrl.sv
// Sequencer walking the 3x3 convolution over the image, then the fully-connected layer,
// issuing one registered address beat per accepted cycle and pulsing done at the end.
// CNN_SEQ_PERF_EN adds a saturating busy-cycle counter (perf_cycles).
module cnn_seq_ctrl #(
    parameter int IMG_W = 28,
    parameter int KER_W = 3,
    parameter int N_OUT = 10
) (
    input logic            clk,
    input logic            reset,
    cnn_seq_ctrl_if.master bus
);
    import cnn_pkg::IMG_AW;
    import cnn_pkg::FEAT_AW;
    import cnn_pkg::WT_AW;
    import cnn_pkg::state_t;
    import cnn_pkg::ST_IDLE;
    import cnn_pkg::ST_CONV;
    import cnn_pkg::ST_FC;
    import cnn_pkg::ST_DONE;

    localparam int FEAT_W = IMG_W - KER_W + 1;
    localparam int N_FEAT = FEAT_W * FEAT_W;
    localparam int KW = $clog2(KER_W);
    localparam int PW = $clog2(FEAT_W);
    localparam int FW = $clog2(N_FEAT);
    localparam int OW = $clog2(N_OUT);

    localparam logic [3:0]    LAST_TAP  = 4'(KER_W * KER_W - 1);
    localparam logic [KW-1:0] LAST_K    = KW'(KER_W - 1);
    localparam logic [FW-1:0] LAST_FEAT = FW'(N_FEAT - 1);

    state_t state;

    logic accept_start, conv_adv, fc_adv;
    logic kx_wrap, ky_wrap, c_wrap, r_wrap, f_wrap, o_wrap;
    logic [KW-1:0] kx_nxt, ky_nxt;
    logic [PW-1:0] c_nxt, r_nxt;
    logic [FW-1:0] f_nxt;
    logic [OW-1:0] o_nxt;
    logic unused_cnt;

    logic [IMG_AW-1:0] win_base, win_base_n;
    logic [IMG_AW-1:0] tap_row, tap_row_n;

    assign accept_start = (state == ST_IDLE) && bus.start;
    assign conv_adv     = bus.conv_vld && bus.rdy;
    assign fc_adv       = bus.fc_vld && bus.rdy;
    assign unused_cnt   = ^{c_nxt, r_nxt};

    cnn_nested_cnt #(.W(KW), .MAX(KER_W - 1)) u_kx (
        .clk(clk), .reset(reset), .clr(accept_start), .en(conv_adv), .nxt(kx_nxt), .wrap(kx_wrap));
    cnn_nested_cnt #(.W(KW), .MAX(KER_W - 1)) u_ky (
        .clk(clk), .reset(reset), .clr(accept_start), .en(kx_wrap), .nxt(ky_nxt), .wrap(ky_wrap));
    cnn_nested_cnt #(.W(PW), .MAX(FEAT_W - 1)) u_c (
        .clk(clk), .reset(reset), .clr(accept_start), .en(ky_wrap), .nxt(c_nxt), .wrap(c_wrap));
    cnn_nested_cnt #(.W(PW), .MAX(FEAT_W - 1)) u_r (
        .clk(clk), .reset(reset), .clr(accept_start), .en(c_wrap), .nxt(r_nxt), .wrap(r_wrap));
    cnn_nested_cnt #(.W(FW), .MAX(N_FEAT - 1)) u_f (
        .clk(clk), .reset(reset), .clr(accept_start), .en(fc_adv), .nxt(f_nxt), .wrap(f_wrap));
    cnn_nested_cnt #(.W(OW), .MAX(N_OUT - 1)) u_o (
        .clk(clk), .reset(reset), .clr(accept_start), .en(f_wrap), .nxt(o_nxt), .wrap(o_wrap));

    // Window origin steps one pixel per output column and jumps by KER_W at row end
    always_comb begin
        win_base_n = win_base;
        tap_row_n  = tap_row;
        if (c_wrap) begin
            win_base_n = win_base + IMG_AW'(KER_W);
        end else if (ky_wrap) begin
            win_base_n = win_base + IMG_AW'(1);
        end
        if (ky_wrap) begin
            tap_row_n = '0;
        end else if (kx_wrap) begin
            tap_row_n = tap_row + IMG_AW'(IMG_W);
        end
    end

    // Main FSM and registered beat outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.conv_vld  <= 1'b0;
            bus.fc_vld    <= 1'b0;
            bus.img_addr  <= '0;
            bus.ker_idx   <= '0;
            bus.feat_addr <= '0;
            bus.wt_addr   <= '0;
            bus.out_idx   <= '0;
            bus.acc_clr   <= 1'b0;
            bus.acc_last  <= 1'b0;
            win_base      <= '0;
            tap_row       <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state         <= ST_CONV;
                        bus.busy      <= 1'b1;
                        bus.conv_vld  <= 1'b1;
                        bus.img_addr  <= '0;
                        bus.ker_idx   <= '0;
                        bus.feat_addr <= '0;
                        bus.acc_clr   <= 1'b1;
                        bus.acc_last  <= 1'b0;
                        win_base      <= '0;
                        tap_row       <= '0;
                    end
                end
                ST_CONV: begin
                    if (conv_adv) begin
                        if (r_wrap) begin
                            state         <= ST_FC;
                            bus.conv_vld  <= 1'b0;
                            bus.fc_vld    <= 1'b1;
                            bus.img_addr  <= '0;
                            bus.ker_idx   <= '0;
                            bus.feat_addr <= '0;
                            bus.wt_addr   <= '0;
                            bus.out_idx   <= '0;
                            bus.acc_clr   <= 1'b1;
                            bus.acc_last  <= 1'b0;
                            win_base      <= '0;
                            tap_row       <= '0;
                        end else begin
                            win_base     <= win_base_n;
                            tap_row      <= tap_row_n;
                            bus.img_addr <= win_base_n + tap_row_n + IMG_AW'(kx_nxt);
                            bus.ker_idx  <= (bus.ker_idx == LAST_TAP) ? 4'd0 : bus.ker_idx + 4'd1;
                            if (ky_wrap) begin
                                bus.feat_addr <= bus.feat_addr + FEAT_AW'(1);
                            end
                            bus.acc_clr  <= (ky_nxt == '0) && (kx_nxt == '0);
                            bus.acc_last <= (ky_nxt == LAST_K) && (kx_nxt == LAST_K);
                        end
                    end
                end
                ST_FC: begin
                    if (fc_adv) begin
                        if (o_wrap) begin
                            state         <= ST_DONE;
                            bus.busy      <= 1'b0;
                            bus.done      <= 1'b1;
                            bus.fc_vld    <= 1'b0;
                            bus.feat_addr <= '0;
                            bus.wt_addr   <= '0;
                            bus.out_idx   <= '0;
                            bus.acc_clr   <= 1'b0;
                            bus.acc_last  <= 1'b0;
                        end else begin
                            bus.feat_addr <= FEAT_AW'(f_nxt);
                            bus.wt_addr   <= f_wrap ? WT_AW'(o_nxt) : bus.wt_addr + WT_AW'(N_OUT);
                            bus.out_idx   <= 4'(o_nxt);
                            bus.acc_clr   <= (f_nxt == '0);
                            bus.acc_last  <= (f_nxt == LAST_FEAT);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CNN_SEQ_PERF_EN
    // Busy-cycle counter: cleared when a run is accepted, saturates, holds after done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.perf_cycles <= '0;
        end else if (accept_start) begin
            bus.perf_cycles <= '0;
        end else if (bus.busy && (bus.perf_cycles != 32'hFFFF_FFFF)) begin
            bus.perf_cycles <= bus.perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cnn_seq_ctrl.sv
// Scoreboard bench for cnn_seq_ctrl: stimulus pushes expected beats and done cycles,
// a negedge monitor pops and compares whenever the DUT accepts a beat or pulses done.
module tb_cnn_seq_ctrl;
    import cnn_pkg::*;

    typedef struct packed {
        logic        is_fc;
        logic [9:0]  img_addr;
        logic [3:0]  ker_idx;
        logic [9:0]  feat_addr;
        logic [12:0] wt_addr;
        logic [3:0]  out_idx;
        logic        acc_clr;
        logic        acc_last;
    } beat_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    cnn_seq_ctrl_if bus();

    cnn_seq_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int edge_cnt     = 0;
    int run_base     = 0;
    int done_cnt     = 0;
    int beat_idx     = 0;
    int conv_beats, fc_beats, conv_clr, conv_last, fc_clr, fc_last;
    int hold_viol, hold_seen, excl_viol;
    logic        prev_hold = 1'b0;
    logic [43:0] prev_raw  = '0;

    beat_t exp_q[$];
    int    done_q[$];

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected beat stream of one complete run, computed directly from loop indices
    task automatic push_run();
        beat_t b;
        for (int r = 0; r < 26; r++)
            for (int c = 0; c < 26; c++)
                for (int ky = 0; ky < 3; ky++)
                    for (int kx = 0; kx < 3; kx++) begin
                        b           = '0;
                        b.img_addr  = 10'((r + ky) * 28 + c + kx);
                        b.ker_idx   = 4'(ky * 3 + kx);
                        b.feat_addr = 10'(r * 26 + c);
                        b.acc_clr   = (ky == 0) && (kx == 0);
                        b.acc_last  = (ky == 2) && (kx == 2);
                        exp_q.push_back(b);
                    end
        for (int o = 0; o < 10; o++)
            for (int f = 0; f < 676; f++) begin
                b           = '0;
                b.is_fc     = 1'b1;
                b.feat_addr = 10'(f);
                b.wt_addr   = 13'(f * 10 + o);
                b.out_idx   = 4'(o);
                b.acc_clr   = (f == 0);
                b.acc_last  = (f == 675);
                exp_q.push_back(b);
            end
    endtask

    task automatic apply_stimulus(input bit expect_done, input int done_cycle);
        tick();
        bus.start  = 1'b1;
        run_base   = edge_cnt;
        beat_idx   = 0;
        conv_beats = 0; fc_beats = 0; conv_clr = 0; conv_last = 0; fc_clr = 0; fc_last = 0;
        hold_viol  = 0; hold_seen = 0; excl_viol = 0;
        push_run();
        if (expect_done) done_q.push_back(done_cycle);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int guard = 0;
        while (done_cnt < target && guard < 30000) begin
            @(negedge clk);
            guard++;
        end
        check_output("done_seen", 64'(done_cnt >= target), 64'd1);
        @(negedge clk);
    endtask

    task automatic end_of_run_checks();
        check_output("beats_left", 64'(exp_q.size()), 64'd0);
        check_output("conv_beats", 64'(conv_beats), 64'd6084);
        check_output("fc_beats", 64'(fc_beats), 64'd6760);
        check_output("conv_clr", 64'(conv_clr), 64'd676);
        check_output("conv_last", 64'(conv_last), 64'd676);
        check_output("fc_clr", 64'(fc_clr), 64'd10);
        check_output("fc_last", 64'(fc_last), 64'd10);
        check_output("vld_exclusive", 64'(excl_viol), 64'd0);
        check_output("idle_after_done", 64'({bus.busy, bus.conv_vld, bus.fc_vld}), 64'd0);
    endtask

    task automatic check_all_zero(input string name);
        check_output(name, 64'({bus.busy, bus.done, bus.conv_vld, bus.fc_vld, bus.img_addr,
                                bus.ker_idx, bus.feat_addr, bus.wt_addr, bus.out_idx,
                                bus.acc_clr, bus.acc_last}), 64'd0);
`ifdef CNN_SEQ_PERF_EN
        check_output({name, "_perf"}, 64'(bus.perf_cycles), 64'd0);
`endif
    endtask

    // Edge counter used as the cycle reference for done timing
    always @(posedge clk) edge_cnt++;

    // Monitor: scoreboard pop on every accepted beat and every done pulse
    always @(negedge clk) begin
        beat_t       act;
        beat_t       exp_b;
        logic [43:0] raw;
        int          cyc;
        raw = {bus.fc_vld, bus.img_addr, bus.ker_idx, bus.feat_addr, bus.wt_addr,
               bus.out_idx, bus.acc_clr, bus.acc_last};
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            cyc = edge_cnt - run_base;
            if (bus.conv_vld && bus.fc_vld) excl_viol++;
            if (prev_hold) begin
                hold_seen++;
                if (raw != prev_raw) hold_viol++;
            end
            if ((bus.conv_vld || bus.fc_vld) && bus.rdy) begin
                act           = '0;
                act.is_fc     = bus.fc_vld;
                act.feat_addr = bus.feat_addr;
                act.acc_clr   = bus.acc_clr;
                act.acc_last  = bus.acc_last;
                if (bus.fc_vld) begin
                    act.wt_addr = bus.wt_addr;
                    act.out_idx = bus.out_idx;
                    fc_beats++;
                    if (bus.acc_clr) fc_clr++;
                    if (bus.acc_last) fc_last++;
                end else begin
                    act.img_addr = bus.img_addr;
                    act.ker_idx  = bus.ker_idx;
                    conv_beats++;
                    if (bus.acc_clr) conv_clr++;
                    if (bus.acc_last) conv_last++;
                end
                if (beat_idx == 0) check_output("spot_b0_img", 64'(act.img_addr), 64'd0);
                if (beat_idx == 8) begin
                    check_output("spot_b8_img", 64'(act.img_addr), 64'd58);
                    check_output("spot_b8_ker", 64'(act.ker_idx), 64'd8);
                    check_output("spot_b8_last", 64'(act.acc_last), 64'd1);
                end
                if (beat_idx == 6083) begin
                    check_output("spot_conv_end_img", 64'(act.img_addr), 64'd783);
                    check_output("spot_conv_end_feat", 64'(act.feat_addr), 64'd675);
                end
                if (beat_idx == 6760) begin
                    check_output("spot_fc_o1_wt", 64'(act.wt_addr), 64'd1);
                    check_output("spot_fc_o1_feat", 64'(act.feat_addr), 64'd0);
                end
                if (beat_idx == 12843) check_output("spot_fc_end_wt", 64'(act.wt_addr), 64'd6759);
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL beat_unexpected: got 0x%0h, expected no beat", act);
                end else begin
                    exp_b = exp_q.pop_front();
                    check_output("beat", 64'(act), 64'(exp_b));
                end
                beat_idx++;
            end
            if (bus.done) begin
                if (done_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL done_unexpected: got done at cycle %0d, expected none", cyc);
                end else begin
                    check_output("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
                    check_output("busy_at_done", 64'(bus.busy), 64'd0);
                end
                done_cnt++;
            end
            prev_hold = (bus.conv_vld || bus.fc_vld) && !bus.rdy;
            prev_raw  = raw;
        end
    end

    // Watchdog so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed stimulus sequence
    initial begin
        int zeros;
        bus.start = 1'b0;
        bus.rdy   = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        tick();
        reset = 1'b0;
        repeat (2) tick();
        check_all_zero("idle_outputs");

        $display("[TB] run A: rdy tied high");
        apply_stimulus(1'b1, 12845);
        wait_done(1);
        end_of_run_checks();
`ifdef CNN_SEQ_PERF_EN
        check_output("perf_after_done", 64'(bus.perf_cycles), 64'd12844);
        repeat (100) @(negedge clk);
        check_output("perf_hold", 64'(bus.perf_cycles), 64'd12844);
`endif

        $display("[TB] run B: stray start pulses mid-run");
        apply_stimulus(1'b1, 12845);
        while (edge_cnt - run_base < 100) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        while (edge_cnt - run_base < 7000) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(2);
        end_of_run_checks();

        $display("[TB] run C: random backpressure");
        apply_stimulus(1'b0, 0);
        zeros = 0;
        for (int k = 0; k < 4000; k++) begin
            bus.rdy = 1'($urandom_range(0, 1));
            if (!bus.rdy) zeros++;
            tick();
        end
        bus.rdy = 1'b1;
        done_q.push_back(12845 + zeros);
        wait_done(3);
        end_of_run_checks();
        check_output("hold_stable", 64'(hold_viol), 64'd0);
        check_output("holds_exercised", 64'(hold_seen > 0), 64'd1);

        $display("[TB] run D: reset mid-run then restart");
        apply_stimulus(1'b0, 0);
        while (edge_cnt - run_base < 5000) tick();
        reset = 1'b1;
        exp_q.delete();
        done_q.delete();
        @(negedge clk);
        check_all_zero("reset_midrun");
        tick();
        reset = 1'b0;
        repeat (2) tick();
        apply_stimulus(1'b1, 12845);
        wait_done(4);
        end_of_run_checks();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
